// File: rtl/decoder_scan_n_if.sv
// Bus bundle for decoder_scan_n: enable, mode, address in; one-hot select, index and wrap out.
// The dir signal exists only when DECODER_SCAN_DIR_EN is defined.
interface decoder_scan_n_if #(parameter int N = 2);
    logic              en;
    logic              mode;
`ifdef DECODER_SCAN_DIR_EN
    logic              dir;
`endif
    logic [N-1:0]      A;
    logic [(1<<N)-1:0] O;
    logic [N-1:0]      idx;
    logic              wrap;

`ifdef DECODER_SCAN_DIR_EN
    modport master (output en, mode, dir, A, input O, idx, wrap);
    modport slave  (input en, mode, dir, A, output O, idx, wrap);
`else
    modport master (output en, mode, A, input O, idx, wrap);
    modport slave  (input en, mode, A, output O, idx, wrap);
`endif
endinterface

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode holding each index DWELL cycles.
// Optional macro DECODER_SCAN_DIR_EN adds a dir input (1 = scan downwards).
module decoder_scan_n #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    decoder_scan_n_if.slave  bus
);
    localparam int W  = 1 << N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [N-1:0]  idx_q, idx_next;
    logic [W-1:0]  o_q, o_next;
    logic          wrap_q, wrap_next;
    logic          down;

`ifdef DECODER_SCAN_DIR_EN
    assign down = bus.dir;
`else
    assign down = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (bus.en) begin
            state_next = bus.mode ? SCAN : DECODE;
        end
    end

    // Outputs are derived from the state being entered, so decode has one cycle of latency
    // and a fresh entry into SCAN restarts the dwell count at the current index.
    always_comb begin
        cnt_next  = '0;
        idx_next  = idx_q;
        wrap_next = 1'b0;
        unique case (state_next)
            DECODE: idx_next = bus.A;
            SCAN: begin
                if (state == SCAN) begin
                    if (cnt == LAST) begin
                        idx_next  = down ? (idx_q - 1'b1) : (idx_q + 1'b1);
                        wrap_next = down ? (idx_q == '0) : (idx_q == '1);
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        o_next = (state_next == IDLE) ? '0 : (W'(1) << idx_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx_q  <= '0;
            o_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            idx_q  <= idx_next;
            o_q    <= o_next;
            wrap_q <= wrap_next;
        end
    end

    assign bus.O    = o_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the decode/scan rules.
module tb_decoder_scan_n;
    localparam int N     = 2;
    localparam int DWELL = 3;
    localparam int W     = 1 << N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    decoder_scan_n_if #(.N(N)) bus ();

    decoder_scan_n #(.N(N), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    bit compare_on = 1'b0;
    bit sc_en      = 1'b0;
    bit sc_mode    = 1'b0;

    int m_idx      = 0;
    bit m_on       = 1'b0;
    bit m_wrap     = 1'b0;
    bit m_scanning = 1'b0;
    int m_hold     = 0;
    logic model_dir;

`ifdef DECODER_SCAN_DIR_EN
    assign model_dir = bus.dir;
`else
    assign model_dir = 1'b0;
`endif

    // m_hold counts how many cycles the current scan index has already been shown.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx <= 0; m_on <= 1'b0; m_wrap <= 1'b0; m_scanning <= 1'b0; m_hold <= 0;
        end else if (!bus.en) begin
            m_on <= 1'b0; m_wrap <= 1'b0; m_scanning <= 1'b0;
        end else if (!bus.mode) begin
            m_idx <= int'(bus.A); m_on <= 1'b1; m_wrap <= 1'b0; m_scanning <= 1'b0;
        end else if (!m_scanning) begin
            m_on <= 1'b1; m_scanning <= 1'b1; m_hold <= 1; m_wrap <= 1'b0;
        end else if (m_hold < DWELL) begin
            m_hold <= m_hold + 1; m_wrap <= 1'b0;
        end else begin
            m_hold <= 1;
            if (model_dir) begin
                m_idx  <= (m_idx + W - 1) % W;
                m_wrap <= (m_idx == 0);
            end else begin
                m_idx  <= (m_idx + 1) % W;
                m_wrap <= (m_idx == W - 1);
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit m, input int a, input bit d);
        bus.en   = e;
        bus.mode = m;
        bus.A    = N'(a);
`ifdef DECODER_SCAN_DIR_EN
        bus.dir  = d;
`else
        if (d) begin end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (compare_on) begin
            checkOutput("model_O", int'(bus.O), m_on ? (1 << m_idx) : 0);
            checkOutput("model_idx", int'(bus.idx), m_idx);
            checkOutput("model_wrap", int'(bus.wrap), int'(m_wrap));
            checkOutput("onehot", ($countones(bus.O) <= 1) ? 1 : 0, 1);
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        #12;
        compare_on = 1'b1;
        checkOutput("reset_O", int'(bus.O), 0);
        checkOutput("reset_idx", int'(bus.idx), 0);
        checkOutput("reset_wrap", int'(bus.wrap), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 2, 1'b0); step();
        checkOutput("decode2_O", int'(bus.O), 4);
        checkOutput("decode2_idx", int'(bus.idx), 2);
        applyStimulus(1'b0, 1'b0, 2, 1'b0); step();
        checkOutput("disable_O", int'(bus.O), 0);
        checkOutput("disable_idx", int'(bus.idx), 2);
        applyStimulus(1'b1, 1'b0, 3, 1'b0); step();
        checkOutput("decode3_O", int'(bus.O), 8);
        applyStimulus(1'b1, 1'b0, 0, 1'b0); step();
        checkOutput("decode0_O", int'(bus.O), 1);

        // Full up-scan from index 0: each select held DWELL cycles, wrap on the return to 0001.
        applyStimulus(1'b1, 1'b1, 0, 1'b0);
        for (int i = 0; i <= 4 * DWELL; i++) begin
            step();
            checkOutput("scan_O", int'(bus.O), 1 << ((i / DWELL) % W));
            checkOutput("scan_wrap", int'(bus.wrap), (i == 4 * DWELL) ? 1 : 0);
        end

        sc_en   = 1'b1;
        sc_mode = 1'b1;
        for (int c = 0; c < 500; c++) begin
            sc_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) sc_mode = ~sc_mode;
            applyStimulus(sc_en, sc_mode, int'($urandom_range(0, W - 1)), 1'($urandom_range(0, 1)));
            step();
        end

        applyStimulus(1'b1, 1'b1, 0, 1'b0);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_O", int'(bus.O), 0);
        checkOutput("midreset_idx", int'(bus.idx), 0);
        checkOutput("midreset_wrap", int'(bus.wrap), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i <= DWELL; i++) begin
            step();
            checkOutput("restart_O", int'(bus.O), (i < DWELL) ? 1 : 2);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
